// File: rtl/ldpc_hard_decision_syndrome_check.sv
// Hard-decision slicer and parity-check syndrome stage that sits after the
// belief-propagation decoder. It captures one posterior vector, slices it to a
// codeword, evaluates one H row per cycle, and hands the codeword and syndrome
// to the consumer over valid/ready. It also keeps saturating frame and error
// counters.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// HARD  | slice captured posteriors into codeword, clear syndrome/row counter
// CHECK | evaluate one parity-check row per cycle
// DONE  | result presented; wait for out_ready
module ldpc_hard_decision_syndrome_check #(
  parameter int N_VARS    = 6,
  parameter int N_CHECKS  = 3,
  parameter int WIDTH     = 32,
  parameter logic [N_VARS*N_CHECKS-1:0] H_MATRIX = 18'b110100_011010_100011,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH*N_VARS-1:0] sum_vector,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_VARS-1:0]       codeword,
  output logic [N_CHECKS-1:0]     syndrome,
  output logic                    syndrome_ok,
  output logic [CNT_WIDTH-1:0]    frame_count,
  output logic [CNT_WIDTH-1:0]    error_count
);

  localparam int ROW_W = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_CHECKS - 1);

  typedef enum logic [1:0] {IDLE, HARD, CHECK, DONE} state_t;

  state_t                  state;
  logic [WIDTH*N_VARS-1:0] cap;
  logic [ROW_W-1:0]        row_cnt;
  logic [N_VARS-1:0]       hard_bits;
  logic [N_CHECKS-1:0]     syn_next;

  // Slice each captured word: negative with non-zero magnitude -> 1.
  // -0.0 maps to 0; NaN/Inf fall out by sign because their magnitude is non-zero.
  always_comb begin
    logic [WIDTH-1:0] w;
    w         = '0;
    hard_bits = '0;
    for (int i = 0; i < N_VARS; i++) begin
      w = cap[WIDTH*(N_VARS-i)-1 -: WIDTH];
      hard_bits[N_VARS-1-i] = w[WIDTH-1] & (|w[WIDTH-2:0]);
    end
  end

  // Syndrome with the bit for the current row replaced by that row's parity.
  always_comb begin
    syn_next = syndrome;
    for (int r = 0; r < N_CHECKS; r++) begin
      if (row_cnt == ROW_W'(r))
        syn_next[N_CHECKS-1-r] = ^(H_MATRIX[(N_CHECKS-1-r)*N_VARS +: N_VARS] & codeword);
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cap         <= '0;
      codeword    <= '0;
      syndrome    <= '0;
      row_cnt     <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      syndrome_ok <= 1'b0;
      frame_count <= '0;
      error_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap      <= sum_vector;
            in_ready <= 1'b0;
            state    <= HARD;
          end
        end
        HARD: begin
          codeword <= hard_bits;
          syndrome <= '0;
          row_cnt  <= '0;
          state    <= CHECK;
        end
        CHECK: begin
          syndrome <= syn_next;
          row_cnt  <= row_cnt + 1'b1;
          if (row_cnt == LAST_ROW) begin
            out_valid   <= 1'b1;
            syndrome_ok <= ~|syn_next;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (frame_count != '1)
              frame_count <= frame_count + 1'b1;
            if (!syndrome_ok && (error_count != '1))
              error_count <= error_count + 1'b1;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_hard_decision_syndrome_check.sv
// Directed bench for ldpc_hard_decision_syndrome_check with a scoreboard of
// expected results computed from an independent reference model.
module tb_ldpc_hard_decision_syndrome_check;

  localparam int N_VARS    = 6;
  localparam int N_CHECKS  = 3;
  localparam int WIDTH     = 32;
  localparam int CNT_WIDTH = 16;
  localparam logic [N_VARS*N_CHECKS-1:0] H = 18'b110100_011010_100011;

  typedef struct packed {
    logic [N_VARS-1:0]   cw;
    logic [N_CHECKS-1:0] syn;
    logic                ok;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [WIDTH*N_VARS-1:0] sum_vector = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [N_VARS-1:0]       codeword;
  logic [N_CHECKS-1:0]     syndrome;
  logic                    syndrome_ok;
  logic [CNT_WIDTH-1:0]    frame_count;
  logic [CNT_WIDTH-1:0]    error_count;

  int   tests = 0;
  int   fails = 0;
  int   frames_exp = 0;
  int   errs_exp = 0;
  exp_t sb[$];
  exp_t cur;

  ldpc_hard_decision_syndrome_check #(
    .N_VARS(N_VARS), .N_CHECKS(N_CHECKS), .WIDTH(WIDTH),
    .H_MATRIX(H), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .sum_vector(sum_vector),
    .out_valid(out_valid), .out_ready(out_ready),
    .codeword(codeword), .syndrome(syndrome), .syndrome_ok(syndrome_ok),
    .frame_count(frame_count), .error_count(error_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [WIDTH*N_VARS-1:0] mk(input logic [31:0] w0, w1, w2, w3, w4, w5);
    return {w0, w1, w2, w3, w4, w5};
  endfunction

  // Reference model: slice by sign and non-zero magnitude, then XOR the
  // selected bits of each row.
  function automatic exp_t model(input logic [WIDTH*N_VARS-1:0] v);
    exp_t e;
    logic [31:0] w;
    logic p;
    e = '0;
    for (int i = 0; i < N_VARS; i++) begin
      w = v[WIDTH*(N_VARS-i)-1 -: WIDTH];
      e.cw[N_VARS-1-i] = (w[31] == 1'b1) && (w[30:0] != 31'd0);
    end
    for (int r = 0; r < N_CHECKS; r++) begin
      p = 1'b0;
      for (int c = 0; c < N_VARS; c++)
        if (H[(N_CHECKS-r)*N_VARS-1-c] && e.cw[N_VARS-1-c]) p = ~p;
      e.syn[N_CHECKS-1-r] = p;
    end
    e.ok = (e.syn == '0);
    return e;
  endfunction

  task automatic send(input logic [WIDTH*N_VARS-1:0] v);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    sum_vector = v;
    in_valid   = 1'b1;
    sb.push_back(model(v));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result, confirm latency and compare against the scoreboard.
  task automatic expect_result(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, n, 4);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
      cur = '0;
    end else begin
      cur = sb.pop_front();
    end
    check({tag, "_codeword"}, {26'd0, codeword}, {26'd0, cur.cw});
    check({tag, "_syndrome"}, {29'd0, syndrome}, {29'd0, cur.syn});
    check({tag, "_syndrome_ok"}, {31'd0, syndrome_ok}, {31'd0, cur.ok});
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    frames_exp++;
    if (!cur.ok) errs_exp++;
    check({tag, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_frame_count"}, {16'd0, frame_count}, frames_exp);
    check({tag, "_error_count"}, {16'd0, error_count}, errs_exp);
  endtask

  initial begin
    logic [WIDTH*N_VARS-1:0] base, v;
    base = mk(32'h3FB70A3D, 32'h3DCCCCCD, 32'h3F0A3D71, 32'h3E6B851F, 32'h3CF5C28F, 32'h3F59999A);

    #12;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_codeword", {26'd0, codeword}, 32'd0);
    check("reset_syndrome", {29'd0, syndrome}, 32'd0);
    check("reset_counts", {frame_count, error_count}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_frame", {31'd0, out_valid}, 32'd0);

    out_ready = 1'b1;
    send(base);
    expect_result("all_pos");
    handshake("all_pos");

    v = base; v[WIDTH*N_VARS-1 -: WIDTH] = 32'hBFB70A3D;
    send(v);
    expect_result("w0_neg");
    handshake("w0_neg");

    send(mk(32'hBF800000, 32'hBF800000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h3F800000));
    expect_result("w014_neg");
    handshake("w014_neg");

    send(mk(32'h3F800000, 32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3F800000, 32'h3F800000));
    expect_result("neg_zero");
    handshake("neg_zero");

    // Back-pressure: result held while out_ready is low, new input ignored.
    out_ready = 1'b0;
    send(mk(32'hFF800000, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 32'hBF800000, 32'h3F800000));
    expect_result("hold");
    for (int k = 0; k < 10; k++) begin
      in_valid   = 1'b1;
      sum_vector = mk(32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000);
      @(posedge clk); #1;
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_result", {23'd0, codeword, syndrome}, {23'd0, cur.cw, cur.syn});
      check("hold_frame_count", {16'd0, frame_count}, frames_exp);
    end
    in_valid = 1'b0;
    handshake("hold");
    @(posedge clk); #1;
    check("after_hold_idle", {30'd0, out_valid, in_ready}, 32'd1);

    // Reset in the middle of CHECK aborts the frame.
    send(v);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_result", {22'd0, codeword, syndrome, syndrome_ok}, 32'd0);
    check("midreset_counts", {frame_count, error_count}, 32'd0);
    sb.delete();
    frames_exp = 0;
    errs_exp   = 0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("post_reset_idle", {30'd0, out_valid, in_ready}, 32'd1);

    out_ready = 1'b1;
    send(v);
    expect_result("post_reset");
    handshake("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
